// File: rtl/mmio_bus_decoder_if.sv
// Load/store port bundle between the core, data RAM and the peripheral slots.
// The decoder takes the slave modport; the core/RAM/peripheral side takes master.
interface mmio_bus_decoder_if #(
    parameter int WIDTH = 32,
    parameter int NSLV  = 2
);
    logic [WIDTH-1:0]      cpu_addr;
    logic [WIDTH-1:0]      cpu_wdata;
    logic                  cpu_we;
    logic                  cpu_re;
    logic [WIDTH-1:0]      cpu_rdata;
    logic                  cpu_stall;
    logic                  cpu_err;
    logic                  mem_we;
    logic [WIDTH-1:0]      mem_rdata;
    logic [NSLV-1:0]       slv_sel;
    logic                  slv_we;
    logic [WIDTH-1:0]      slv_wdata;
    logic [NSLV*WIDTH-1:0] slv_rdata;
    logic [NSLV-1:0]       slv_ready;
    logic                  err_flag;
    logic [WIDTH-1:0]      err_addr;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, slv_rdata, slv_ready,
        output cpu_rdata, cpu_stall, cpu_err, mem_we, slv_sel, slv_we, slv_wdata,
               err_flag, err_addr
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, slv_rdata, slv_ready,
        input  cpu_rdata, cpu_stall, cpu_err, mem_we, slv_sel, slv_we, slv_wdata,
               err_flag, err_addr
    );
endinterface

// File: rtl/mmio_bus_decoder.sv
// MMIO decoder: zero-wait RAM path plus a stalling IDLE/ACCESS/DONE handshake to NSLV slots.
// Define BUS_TIMEOUT_EN to build the ACCESS watchdog, cpu_err pulse and sticky err_flag/err_addr.
module mmio_bus_decoder #(
    parameter int                    WIDTH    = 32,
    parameter int                    NSLV     = 2,
    parameter logic [NSLV*WIDTH-1:0] SLV_BASE = {32'h0000_0040, 32'h0000_001F},
    parameter logic [NSLV*WIDTH-1:0] SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFFF},
    parameter int                    TIMEOUT  = 15
) (
    input logic               clk,
    input logic               reset_n,
    mmio_bus_decoder_if.slave bus
);
    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 15 || NSLV < 1 || NSLV > 8) begin : g_bad_param
            $error("mmio_bus_decoder: TIMEOUT must be 1..15 and NSLV 1..8");
        end
    endgenerate

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             we_q;
    logic [WIDTH-1:0] rdata_q;

    logic             req;
    logic [NSLV-1:0]  hit;
    logic             any_hit;
    logic [IDXW-1:0]  hit_idx;
    logic             ready_sel;
    logic [WIDTH-1:0] rdata_sel;

    assign req       = bus.cpu_we | bus.cpu_re;
    assign ready_sel = bus.slv_ready[idx];
    assign rdata_sel = bus.slv_rdata[int'(idx)*WIDTH +: WIDTH];

    always_comb begin
        hit = '0;
        for (int k = 0; k < NSLV; k++)
            hit[k] = (bus.cpu_addr & SLV_MASK[k*WIDTH +: WIDTH]) ==
                     (SLV_BASE[k*WIDTH +: WIDTH] & SLV_MASK[k*WIDTH +: WIDTH]);
    end

    // Scan high to low so the lowest-indexed overlapping slot is the last writer.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--)
            if (hit[k]) begin
                any_hit = 1'b1;
                hit_idx = IDXW'(k);
            end
    end

`ifdef BUS_TIMEOUT_EN
    logic [3:0]       cnt;
    logic             err_q;
    logic             flag_q;
    logic [WIDTH-1:0] eaddr_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
            eaddr_q <= '0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req && any_hit) begin
                        idx   <= hit_idx;
                        we_q  <= bus.cpu_we;
                        state <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                ACCESS: begin
`ifdef BUS_TIMEOUT_EN
                    if (cnt != 4'hF) cnt <= cnt + 4'd1;
`endif
                    // Writes still capture the slot's read data; the core ignores it.
                    if (ready_sel) begin
                        rdata_q <= rdata_sel;
                        state   <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt == 4'(TIMEOUT)) begin
                        rdata_q <= '1;
                        state   <= DONE;
                        err_q   <= 1'b1;
                        flag_q  <= 1'b1;
                        if (!flag_q) eaddr_q <= bus.cpu_addr;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [NSLV-1:0]  sel_c;
    logic             slv_we_c;
    logic             stall_c;
    logic             mem_we_c;
    logic [WIDTH-1:0] rdata_c;

    // Outputs are gated by reset_n so an asserted reset silences the bus at once.
    always_comb begin
        sel_c    = '0;
        slv_we_c = 1'b0;
        stall_c  = 1'b0;
        mem_we_c = 1'b0;
        rdata_c  = bus.mem_rdata;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (req && any_hit) begin
                        sel_c[hit_idx] = 1'b1;
                        slv_we_c       = bus.cpu_we;
                        stall_c        = 1'b1;
                    end else begin
                        mem_we_c = bus.cpu_we;
                    end
                end
                ACCESS: begin
                    sel_c[idx] = 1'b1;
                    slv_we_c   = we_q;
                    stall_c    = 1'b1;
                end
                DONE:    rdata_c = rdata_q;
                default: ;
            endcase
        end
    end

    assign bus.slv_sel   = sel_c;
    assign bus.slv_we    = slv_we_c;
    assign bus.cpu_stall = stall_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.cpu_rdata = rdata_c;
    assign bus.slv_wdata = bus.cpu_wdata;

`ifdef BUS_TIMEOUT_EN
    assign bus.cpu_err  = err_q;
    assign bus.err_flag = flag_q;
    assign bus.err_addr = eaddr_q;
`else
    assign bus.cpu_err  = 1'b0;
    assign bus.err_flag = 1'b0;
    assign bus.err_addr = '0;
`endif
endmodule
